// File: rtl/bcd_conv_hs.sv
// Sequential binary-to-BCD converter (shift-add-3) with a req/busy/valid handshake.
// Optional macro BCD_CONV_HS_BLANK_EN adds a registered leading-zero blank mask.
module bcd_conv_hs #(
    parameter int DATA_W    = 20,
    parameter int DIGITS    = 6,
    parameter int SIGNED_IN = 0
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  req,
    input  logic [DATA_W-1:0]     data,
    output logic                  busy,
    output logic                  bcd_valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  sign_out,
    output logic                  ovf
`ifdef BCD_CONV_HS_BLANK_EN
   ,output logic [DIGITS-1:0]     blank
`endif
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mag_q, mag_d;
    logic [BCD_W-1:0]  acc_q, acc_d;
    logic              ovf_st_q, ovf_st_d;
    logic              sign_q, sign_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              sign_out_q, sign_out_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;
    logic [BCD_W-1:0]  acc_adj;
`ifdef BCD_CONV_HS_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d, blank_nx;
    logic              hi_zero;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        mag_d      = mag_q;
        acc_d      = acc_q;
        ovf_st_d   = ovf_st_q;
        sign_d     = sign_q;
        bcd_d      = bcd_q;
        sign_out_d = sign_out_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;

        acc_adj = acc_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc_q[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (SIGNED_IN != 0 && data[DATA_W-1]) begin
                        mag_d  = (~data) + DATA_W'(1);
                        sign_d = 1'b1;
                    end else begin
                        mag_d  = data;
                        sign_d = 1'b0;
                    end
                    acc_d    = '0;
                    ovf_st_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // The top digit's carry-out is dropped from the result and only remembered as overflow.
                {acc_d, mag_d} = {acc_adj[BCD_W-2:0], mag_q, 1'b0};
                if (acc_adj[BCD_W-1]) begin
                    ovf_st_d = 1'b1;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d      = acc_q;
                sign_out_d = sign_q;
                ovf_d      = ovf_st_q;
                valid_d    = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef BCD_CONV_HS_BLANK_EN
    always_comb begin
        hi_zero  = 1'b1;
        blank_nx = '0;
        for (int d = DIGITS - 1; d > 0; d--) begin
            hi_zero     = hi_zero & (acc_q[4*d +: 4] == 4'd0);
            blank_nx[d] = hi_zero & ~ovf_st_q;
        end
        blank_d = (state_q == ST_DONE) ? blank_nx : blank_q;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mag_q      <= '0;
            acc_q      <= '0;
            ovf_st_q   <= 1'b0;
            sign_q     <= 1'b0;
            bcd_q      <= '0;
            sign_out_q <= 1'b0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
`ifdef BCD_CONV_HS_BLANK_EN
            blank_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mag_q      <= mag_d;
            acc_q      <= acc_d;
            ovf_st_q   <= ovf_st_d;
            sign_q     <= sign_d;
            bcd_q      <= bcd_d;
            sign_out_q <= sign_out_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
`ifdef BCD_CONV_HS_BLANK_EN
            blank_q    <= blank_d;
`endif
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign bcd_valid = valid_q;
    assign bcd       = bcd_q;
    assign sign_out  = sign_out_q;
    assign ovf       = ovf_q;
`ifdef BCD_CONV_HS_BLANK_EN
    assign blank     = blank_q;
`endif

endmodule

// File: tb/tb_bcd_conv_hs.sv
// Scoreboard bench for bcd_conv_hs: an unsigned and a signed instance, directed vectors,
// expected results queued at issue time and checked by per-instance monitors.
module tb_bcd_conv_hs;

    typedef struct packed {
        logic [23:0] bcd;
        logic        sign;
        logic        ovf;
        logic [5:0]  blank;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        req_u, req_s;
    logic [19:0] data_u, data_s;
    logic        busy_u, busy_s, valid_u, valid_s, sign_u, sign_s, ovf_u, ovf_s;
    logic [23:0] bcd_u, bcd_s;
    logic [5:0]  blank_u, blank_s;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q_uns[$];
    exp_t q_sgn[$];
    exp_t last_u = '0;
    exp_t last_s = '0;
    exp_t e_u, e_s;

    always #5 sys_clk = ~sys_clk;

    bcd_conv_hs #(.DATA_W(20), .DIGITS(6), .SIGNED_IN(0)) u_uns (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req(req_u), .data(data_u),
        .busy(busy_u), .bcd_valid(valid_u), .bcd(bcd_u), .sign_out(sign_u), .ovf(ovf_u)
`ifdef BCD_CONV_HS_BLANK_EN
       ,.blank(blank_u)
`endif
    );

    bcd_conv_hs #(.DATA_W(20), .DIGITS(6), .SIGNED_IN(1)) u_sgn (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req(req_s), .data(data_s),
        .busy(busy_s), .bcd_valid(valid_s), .bcd(bcd_s), .sign_out(sign_s), .ovf(ovf_s)
`ifdef BCD_CONV_HS_BLANK_EN
       ,.blank(blank_s)
`endif
    );

`ifndef BCD_CONV_HS_BLANK_EN
    assign blank_u = '0;
    assign blank_s = '0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [23:0] b, input logic s, input logic o, input logic [5:0] bl);
        exp_t e;
        e.bcd = b; e.sign = s; e.ovf = o; e.blank = bl;
        return e;
    endfunction

    task automatic drive(input bit sel, input logic r, input logic [19:0] d);
        if (sel) begin req_s = r; data_s = d; end
        else     begin req_u = r; data_u = d; end
    endtask

    function automatic logic valid_of(input bit sel);
        return sel ? valid_s : valid_u;
    endfunction

    function automatic logic busy_of(input bit sel);
        return sel ? busy_s : busy_u;
    endfunction

    // Called #1 after a rising edge with the selected instance idle; returns in its valid cycle.
    task automatic run(input bit sel, input logic [19:0] value, input exp_t e);
        int edges;
        int busy_cnt;
        if (sel) q_sgn.push_back(e); else q_uns.push_back(e);
        drive(sel, 1'b1, value);
        @(posedge sys_clk); #1;
        edges = 0;
        busy_cnt = 0;
        while (!valid_of(sel) && edges < 100) begin
            if (busy_of(sel)) busy_cnt++;
            drive(sel, 1'($urandom), 20'($urandom));
            @(posedge sys_clk); #1;
            edges++;
        end
        drive(sel, 1'b0, 20'h0);
        check("latency_edges", edges, 21);
        check("busy_cycles", busy_cnt, 21);
        check("busy_in_valid_cycle", {31'd0, busy_of(sel)}, 0);
    endtask

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            last_u = '0;
        end else if (valid_u) begin
            if (q_uns.size() == 0) begin
                check("u_spurious_valid", 1, 0);
            end else begin
                e_u = q_uns.pop_front();
                check("u_bcd", {8'd0, bcd_u}, {8'd0, e_u.bcd});
                check("u_sign", {31'd0, sign_u}, {31'd0, e_u.sign});
                check("u_ovf", {31'd0, ovf_u}, {31'd0, e_u.ovf});
`ifdef BCD_CONV_HS_BLANK_EN
                check("u_blank", {26'd0, blank_u}, {26'd0, e_u.blank});
`endif
                last_u = e_u;
            end
        end else begin
            check("u_hold_bcd", {8'd0, bcd_u}, {8'd0, last_u.bcd});
            check("u_hold_ovf", {31'd0, ovf_u}, {31'd0, last_u.ovf});
        end
    end

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            last_s = '0;
        end else if (valid_s) begin
            if (q_sgn.size() == 0) begin
                check("s_spurious_valid", 1, 0);
            end else begin
                e_s = q_sgn.pop_front();
                check("s_bcd", {8'd0, bcd_s}, {8'd0, e_s.bcd});
                check("s_sign", {31'd0, sign_s}, {31'd0, e_s.sign});
                check("s_ovf", {31'd0, ovf_s}, {31'd0, e_s.ovf});
`ifdef BCD_CONV_HS_BLANK_EN
                check("s_blank", {26'd0, blank_s}, {26'd0, e_s.blank});
`endif
                last_s = e_s;
            end
        end else begin
            check("s_hold_bcd", {8'd0, bcd_s}, {8'd0, last_s.bcd});
            check("s_hold_sign", {31'd0, sign_s}, {31'd0, last_s.sign});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   seen;
        int   saw_valid;
        time  t1, t2;

        sys_rst_n = 1'b0;
        drive(0, 1'b0, 20'h0);
        drive(1, 1'b0, 20'h0);
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        check("rst_busy", {30'd0, busy_u, busy_s}, 0);
        check("rst_valid", {30'd0, valid_u, valid_s}, 0);
        check("rst_bcd", {8'd0, bcd_u | bcd_s}, 0);
        check("rst_flags", {28'd0, sign_u, sign_s, ovf_u, ovf_s}, 0);
        check("rst_blank", {26'd0, blank_u | blank_s}, 0);
        @(posedge sys_clk); #1;

        run(0, 20'd999999, mk(24'h999999, 1'b0, 1'b0, 6'b000000));
        run(0, 20'hFFFFF,  mk(24'h048575, 1'b0, 1'b1, 6'b000000));
        run(0, 20'd0,      mk(24'h000000, 1'b0, 1'b0, 6'b111110));
        run(0, 20'd1230,   mk(24'h001230, 1'b0, 1'b0, 6'b110000));

        run(1, 20'hFFFFF,  mk(24'h000001, 1'b1, 1'b0, 6'b111110));
        run(1, 20'h80000,  mk(24'h524288, 1'b1, 1'b0, 6'b000000));
        run(1, 20'd123456, mk(24'h123456, 1'b0, 1'b0, 6'b000000));
        run(1, 20'd0,      mk(24'h000000, 1'b0, 1'b0, 6'b111110));

        // Back-to-back with req held high; data scrambled except at each accepting edge.
        q_uns.push_back(mk(24'h987654, 1'b0, 1'b0, 6'b000000));
        q_uns.push_back(mk(24'h981106, 1'b0, 1'b0, 6'b000000));
        drive(0, 1'b1, 20'd987654);
        @(posedge sys_clk); #1;
        n = 0; seen = 0; t1 = 0; t2 = 0;
        while (seen < 2 && n < 200) begin
            if (valid_u) begin
                seen++;
                if (seen == 1) begin t1 = $time; drive(0, 1'b1, 20'd981106); end
                else begin t2 = $time; drive(0, 1'b0, 20'h0); end
            end else begin
                drive(0, 1'b1, 20'($urandom));
            end
            if (seen < 2) begin
                @(posedge sys_clk); #1;
                n++;
            end
        end
        drive(0, 1'b0, 20'h0);
        check("b2b_results", seen, 2);
        check("b2b_spacing_ns", 32'(t2 - t1), 220);

        // Abort a conversion with reset after SHIFT cycle 10.
        drive(0, 1'b1, 20'd777777);
        @(posedge sys_clk); #1;
        drive(0, 1'b0, 20'h0);
        repeat (10) @(posedge sys_clk);
        #1 sys_rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy_u}, 0);
        check("abort_valid", {31'd0, valid_u}, 0);
        check("abort_bcd", {8'd0, bcd_u}, 0);
        check("abort_ovf_sign", {30'd0, ovf_u, sign_u}, 0);
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        saw_valid = 0;
        repeat (30) begin
            @(posedge sys_clk); #1;
            if (valid_u) saw_valid = 1;
        end
        check("abort_no_valid", saw_valid, 0);
        run(0, 20'd123456, mk(24'h123456, 1'b0, 1'b0, 6'b000000));

        repeat (3) @(posedge sys_clk);
        check("uns_queue_drained", q_uns.size(), 0);
        check("sgn_queue_drained", q_sgn.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_conv_hs.md
Name: bcd_conv_hs

Overview:
- Parametrised sequential binary-to-BCD converter (shift-add-3 / double dabble), successor to the fixed 20-bit, 6-digit, free-running converter.
- Generalised input width and digit count.
- Adds a req/busy/valid handshake, two's-complement input mode and an overflow flag.
- Sits between arithmetic/counter sources and the dynamic seven-segment driver; its packed BCD bus feeds the digit mux directly.

Parameters:
- DATA_W, 20, binary input width (2..32).
- DIGITS, 6, number of BCD output digits (1..10).
- SIGNED_IN, 0, 0 = data is unsigned; 1 = data is two's complement, magnitude converted, sign reported separately.

Ports:
- sys_clk  in  1  system clock, rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- req  in  1  conversion request; sampled only when busy=0.
- data  in  DATA_W  binary value; captured on the accepting edge.
- busy  out  1  conversion in progress.
- bcd_valid  out  1  one-cycle pulse, result registers updated.
- bcd  out  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0].
- sign_out  out  1  1 = negative input (always 0 when SIGNED_IN=0).
- ovf  out  1  value exceeds 10^DIGITS-1; bcd then holds the low DIGITS digits.

Behaviour:
- Reset (async assert, sync release): state IDLE, busy=0, bcd_valid=0, bcd=0, sign_out=0, ovf=0, internal shift/BCD registers and counter cleared.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: if req=1 at edge E0, capture data, then go to SHIFT.
    - Capture path: if SIGNED_IN=1 and data MSB=1, load magnitude = (~data)+1 as an unsigned DATA_W value; latch sign=1. Otherwise load data; latch sign=0.
    - Clear the BCD accumulator, overflow sticky and counter.
  - SHIFT: one bit per cycle.
    - Add 3 to every accumulator digit that is ≥5.
    - Then shift {accumulator, magnitude} left by 1.
    - A 1 shifted out of the top digit sets the overflow sticky.
    - Counter increments; after DATA_W SHIFT edges (E1..E_DATA_W), go to DONE.
  - DONE: at edge E_(DATA_W+1), register bcd, sign_out and ovf, pulse bcd_valid=1, then go to IDLE.
- Timing:
  - busy=1 from after E0 until E_(DATA_W+1); busy=0 in the cycle where bcd_valid=1.
  - Latency: req edge to bcd_valid visible = DATA_W+1 edges.
  - Back-to-back: req high during the bcd_valid cycle is accepted. Max throughput is one result per DATA_W+2 cycles.
- Boundary conditions:
  - req while busy=1 is ignored; data changes while busy do not affect the result.
  - Outputs bcd, sign_out and ovf hold their last result until the next bcd_valid.
  - data=0 gives bcd=0, ovf=0, sign_out=0 (in both modes; there is no negative zero).
  - SIGNED_IN=1 with the most negative input: magnitude 2^(DATA_W-1) converts correctly; sign_out=1.
  - Overflow: bcd equals the true decimal value mod 10^DIGITS.
  - Reset asserted mid-SHIFT aborts immediately to the reset state; no bcd_valid is issued for the aborted conversion.
- Width rules:
  - Counter width is $clog2(DATA_W+1).
  - The accumulator is exactly 4*DIGITS bits; no guard digit.

Optional Feature:
- Macro: BCD_CONV_HS_BLANK_EN.
- When defined: extra output blank, DIGITS bits wide, registered with bcd at bcd_valid, reset to 0.
  - blank[i]=1 when digit i and all higher digits are 0 and i>0; digit 0 is never blanked.
  - blank is forced to all-0 when ovf=1.
- When undefined: the port does not exist and there is no extra logic.

Test Plan:
- DATA_W=20, DIGITS=6, SIGNED_IN=0, data=999999, req pulse -> bcd=24'h999999, ovf=0, busy high 21 cycles, bcd_valid exactly 21 edges after the accepting edge.
- Same config, data=20'hFFFFF (1048575) -> bcd=24'h048575, ovf=1; then data=0 -> bcd=0, ovf=0.
- SIGNED_IN=1, DATA_W=20: data=20'hFFFFF -> bcd=24'h000001, sign_out=1; data=20'h80000 -> bcd=24'h524288, sign_out=1; data=123456 -> bcd=24'h123456, sign_out=0.
- req held high continuously with data=987654 then 981106 -> two results, bcd_valid pulses exactly 22 cycles apart; data toggled mid-conversion does not alter the result.
- Reset pulsed at SHIFT cycle 10 -> all outputs 0 asynchronously; no bcd_valid appears; next req converts 123456 -> 24'h123456.
- BCD_CONV_HS_BLANK_EN defined, data=1230 -> blank=6'b110000; data=0 -> blank=6'b111110; overflow case -> blank=6'b000000.
